// File: rtl/apb4_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb4_master_pkg                                                      |
// | Shared types and constants for the APB4 initiator bridge.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package apb4_master_pkg;

    localparam int APB4_ALIGN_BITS = 2;
    localparam int APB4_ADDR_W     = 32;
    localparam int APB4_DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic                       write;
        logic [APB4_ADDR_W-1:0]     addr;
        logic [APB4_DATA_W-1:0]     wdata;
        logic [APB4_DATA_W/8-1:0]   strb;
    } apb4_cmd_t;

    typedef struct packed {
        logic [APB4_DATA_W-1:0]     rdata;
        logic                       err;
        logic                       timeout;
    } apb4_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb4_master_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb4_master_bridge_if                                                |
// | APB4 bus bundle; master = initiator side, slave = completer side.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface apb4_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb4_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb4_wait_timer                                                      |
// | Saturating wait-state counter; expired flags the limit-th wait cycle.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb4_wait_timer #(
    parameter int WIDTH = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             enable,
    input  wire logic [WIDTH-1:0] limit,
    output logic                  expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Asserted during the enabled cycle that would be the limit-th one; limit 0 never expires.
    assign expired = enable && (limit != '0) && (r_count >= (limit - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/apb4_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb4_master_bridge                                                   |
// | Valid/ready command/response to APB4 initiator with timeout/align.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module apb4_master_bridge
    import apb4_master_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 32,
    parameter int         DATA_WIDTH     = 32,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [2:0] PPROT_VAL      = 3'b000
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    cmd_valid,
    output logic                         cmd_ready,
    input  wire logic                    cmd_write,
    input  wire logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  wire logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  wire logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                         rsp_valid,
    input  wire logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    apb4_master_bridge_if.master         apb
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    localparam int c_tmr_w  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e    r_state;
    state_e    w_state_nxt;
    apb4_cmd_t r_cmd;
    apb4_cmd_t w_cmd;
    apb4_rsp_t r_rsp;
    apb4_rsp_t w_rsp_nxt;

    logic r_cmd_ready, r_psel, r_penable, r_rsp_valid;
    logic w_cmd_ready_nxt, w_psel_nxt, w_penable_nxt, w_rsp_valid_nxt;
    logic w_accept, w_misaligned, w_tmr_en, w_tmr_expired;

    // cmd_ready is only ever high while in IDLE, so it alone qualifies acceptance.
    assign w_accept     = cmd_valid && r_cmd_ready;
    assign w_misaligned = |cmd_addr[APB4_ALIGN_BITS-1:0];
    assign w_tmr_en     = (r_state == ACCESS) && !apb.pready;

    always_comb begin
        w_cmd       = '0;
        w_cmd.write = cmd_write;
        w_cmd.addr  = APB4_ADDR_W'(cmd_addr);
        w_cmd.wdata = APB4_DATA_W'(cmd_wdata);
        w_cmd.strb  = cmd_write ? (APB4_DATA_W/8)'(cmd_strb) : '0;
    end

    apb4_wait_timer #(
        .WIDTH (c_tmr_w)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .enable  (w_tmr_en),
        .limit   (c_tmr_w'(TIMEOUT_CYCLES)),
        .expired (w_tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_misaligned ? RESP : SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (apb.pready || w_tmr_expired) w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == IDLE);
        w_psel_nxt      = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);
        w_penable_nxt   = (w_state_nxt == ACCESS);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
        w_rsp_nxt       = r_rsp;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_rsp_nxt     = '0;
                    w_rsp_nxt.err = w_misaligned;
                end
            end
            ACCESS: begin
                if (apb.pready) begin
                    w_rsp_nxt.rdata   = (!r_cmd.write && !apb.pslverr) ? APB4_DATA_W'(apb.prdata) : '0;
                    w_rsp_nxt.err     = apb.pslverr;
                    w_rsp_nxt.timeout = 1'b0;
                end else if (w_tmr_expired) begin
                    w_rsp_nxt         = '0;
                    w_rsp_nxt.err     = 1'b1;
                    w_rsp_nxt.timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_cmd       <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp       <= w_rsp_nxt;
            if (w_accept) begin
                r_cmd <= w_cmd;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = DATA_WIDTH'(r_rsp.rdata);
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;

    assign apb.paddr   = ADDR_WIDTH'(r_cmd.addr);
    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwrite  = r_cmd.write;
    assign apb.pwdata  = DATA_WIDTH'(r_cmd.wdata);
    assign apb.pstrb   = c_strb_w'(r_cmd.strb);
    assign apb.pprot   = PPROT_VAL;

endmodule
`default_nettype wire
